// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// State encodings, the per-register enable/clear bundles and the
// register-match helper used by the load-use detector.

package pipeline_hazard_ctrl_pkg;

  // Controller states: normal flow, waiting on data memory, timed out
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } ctrl_state_e;

  // Register $zero never carries a real dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Load enables for PC and the four pipeline registers
  typedef struct packed {
    logic pc;
    logic ifId;
    logic idEx;
    logic exMem;
    logic memWb;
  } ld_vec_t;

  // Synchronous clears (bubble insertion) for the four pipeline registers
  typedef struct packed {
    logic ifId;
    logic idEx;
    logic exMem;
    logic memWb;
  } flush_vec_t;

  // True when a producer register feeds a consumer and is not $zero
  function automatic logic regDepends(input logic [4:0] producer,
                                      input logic [4:0] consumer);
    return (producer != REG_ZERO) && (producer == consumer);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination
// is read by the instruction in ID forces a one-cycle bubble.

module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       EX_MemRead,
  input  logic [4:0] EX_Rt,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  output logic       Hazard
);

  logic rsDep;
  logic rtDep;

  assign rsDep  = regDepends(EX_Rt, ID_Rs);
  assign rtDep  = regDepends(EX_Rt, ID_Rt);
  assign Hazard = EX_MemRead && (rsDep || rtDep);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Tracks multi-cycle data-memory accesses with a timeout, decodes the
// per-register load/flush controls by hazard priority, and keeps a
// saturating count of stalled cycles.

module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
)
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_Jump,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rt,
  input  logic             EX_BranchTaken,
  input  logic             MEM_MemAccess,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             PC_Ld,
  output logic             IF_ID_Ld,
  output logic             ID_EX_Ld,
  output logic             EX_MEM_Ld,
  output logic             MEM_WB_Ld,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic             MEM_WB_Flush,
  output logic             Stall,
  output logic             Err,
  output logic [CNT_W-1:0] StallCycles
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  ctrl_state_e      state_q;
  logic [7:0]       waitCnt_q;
  logic             memReq_q;
  logic             err_q;
  logic [CNT_W-1:0] stallCnt_q;
  logic [CNT_W-1:0] stallCnt_d;

  logic       hazard;
  logic       memStall;
  logic       stallRaw;
  ld_vec_t    ld;
  flush_vec_t flush;

  load_use_detect u_load_use_detect (
    .EX_MemRead (EX_MemRead),
    .EX_Rt      (EX_Rt),
    .ID_Rs      (ID_Rs),
    .ID_Rt      (ID_Rt),
    .Hazard     (hazard)
  );

  // Memory-access FSM: enter MEM_WAIT on a slow access, release on ready, trap to ERR on timeout
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_RUN;
      waitCnt_q <= 8'd0;
      memReq_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (MEM_MemAccess && !MemReady) begin
            state_q   <= ST_MEM_WAIT;
            memReq_q  <= 1'b1;
            waitCnt_q <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (MemReady) begin
            state_q   <= ST_RUN;
            memReq_q  <= 1'b0;
            waitCnt_q <= 8'd0;
          end else if (waitCnt_q == MAX_WAIT_C) begin
            state_q  <= ST_ERR;
            memReq_q <= 1'b0;
            err_q    <= 1'b1;
          end else begin
            waitCnt_q <= waitCnt_q + 8'd1;
          end
        end
        ST_ERR: begin
          memReq_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_RUN;
          memReq_q  <= 1'b0;
          waitCnt_q <= 8'd0;
        end
      endcase
    end
  end

  // Memory freezes the front of the pipe both while waiting and on the cycle a slow access starts
  assign memStall = ((state_q == ST_MEM_WAIT) && !MemReady) ||
                    ((state_q == ST_RUN) && MEM_MemAccess && !MemReady);

  // Priority decode of load enables and flushes: reset, error, memory, branch, load-use, jump
  always_comb begin
    ld    = '1;
    flush = '0;
    if (Rst) begin
      ld    = '0;
      flush = '1;
    end else if (state_q == ST_ERR) begin
      ld = '0;
    end else if (memStall) begin
      ld.pc       = 1'b0;
      ld.ifId     = 1'b0;
      ld.idEx     = 1'b0;
      ld.exMem    = 1'b0;
      flush.memWb = 1'b1;
    end else if (EX_BranchTaken) begin
      flush.ifId = 1'b1;
      flush.idEx = 1'b1;
    end else if (hazard) begin
      ld.pc      = 1'b0;
      ld.ifId    = 1'b0;
      flush.idEx = 1'b1;
    end else if (ID_Jump) begin
      flush.ifId = 1'b1;
    end
  end

  // Reset holds every register cleared, which does not count as a stall
  assign stallRaw = !Rst && !(&ld);

  // Saturating stall counter holds at all-ones instead of wrapping
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (stallRaw && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_W'(1);
    end
  end

  // Stall counter register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign PC_Ld        = ld.pc;
  assign IF_ID_Ld     = ld.ifId;
  assign ID_EX_Ld     = ld.idEx;
  assign EX_MEM_Ld    = ld.exMem;
  assign MEM_WB_Ld    = ld.memWb;
  assign IF_ID_Flush  = flush.ifId;
  assign ID_EX_Flush  = flush.idEx;
  assign EX_MEM_Flush = flush.exMem;
  assign MEM_WB_Flush = flush.memWb;
  assign Stall        = stallRaw;
  assign MemReq       = memReq_q;
  assign Err          = err_q;
  assign StallCycles  = stallCnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl.
// Each scenario task builds a table of per-cycle stimulus with the control
// word and stall count expected in that cycle; the expectation is queued
// when the stimulus is applied and popped when the outputs are sampled.

module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  // Expected control word layout: {Ld PC,IF_ID,ID_EX,EX_MEM,MEM_WB | Flush IF_ID,ID_EX,EX_MEM,MEM_WB | Stall, MemReq, Err}
  localparam logic [11:0] C_RST    = 12'b00000_1111_000;
  localparam logic [11:0] C_RSTREQ = 12'b00000_1111_010;
  localparam logic [11:0] C_RSTERR = 12'b00000_1111_001;
  localparam logic [11:0] C_NONE   = 12'b11111_0000_000;
  localparam logic [11:0] C_LU     = 12'b00111_0100_100;
  localparam logic [11:0] C_BR     = 12'b11111_1100_000;
  localparam logic [11:0] C_JMP    = 12'b11111_1000_000;
  localparam logic [11:0] C_MEM0   = 12'b00001_0001_100;
  localparam logic [11:0] C_MEMW   = 12'b00001_0001_110;
  localparam logic [11:0] C_REL    = 12'b11111_0000_010;
  localparam logic [11:0] C_RELBR  = 12'b11111_1100_010;
  localparam logic [11:0] C_RELLU  = 12'b00111_0100_110;
  localparam logic [11:0] C_ERR    = 12'b00000_0000_101;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic [4:0]       ID_Rs = '0;
  logic [4:0]       ID_Rt = '0;
  logic             ID_Jump = 1'b0;
  logic             EX_MemRead = 1'b0;
  logic [4:0]       EX_Rt = '0;
  logic             EX_BranchTaken = 1'b0;
  logic             MEM_MemAccess = 1'b0;
  logic             MemReady = 1'b0;
  logic             MemReq;
  logic             PC_Ld, IF_ID_Ld, ID_EX_Ld, EX_MEM_Ld, MEM_WB_Ld;
  logic             IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush;
  logic             Stall;
  logic             Err;
  logic [CNT_W-1:0] StallCycles;
  logic [11:0]      obs;

  typedef struct {
    logic             rst;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             jump;
    logic             exRd;
    logic [4:0]       exRt;
    logic             br;
    logic             acc;
    logic             rdy;
    logic [11:0]      ctl;
    logic [CNT_W-1:0] cnt;
  } step_t;

  typedef struct {
    logic [11:0]      ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(CNT_W)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_Jump        (ID_Jump),
    .EX_MemRead     (EX_MemRead),
    .EX_Rt          (EX_Rt),
    .EX_BranchTaken (EX_BranchTaken),
    .MEM_MemAccess  (MEM_MemAccess),
    .MemReady       (MemReady),
    .MemReq         (MemReq),
    .PC_Ld          (PC_Ld),
    .IF_ID_Ld       (IF_ID_Ld),
    .ID_EX_Ld       (ID_EX_Ld),
    .EX_MEM_Ld      (EX_MEM_Ld),
    .MEM_WB_Ld      (MEM_WB_Ld),
    .IF_ID_Flush    (IF_ID_Flush),
    .ID_EX_Flush    (ID_EX_Flush),
    .EX_MEM_Flush   (EX_MEM_Flush),
    .MEM_WB_Flush   (MEM_WB_Flush),
    .Stall          (Stall),
    .Err            (Err),
    .StallCycles    (StallCycles)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 Clk = ~Clk;

  assign obs = {PC_Ld, IF_ID_Ld, ID_EX_Ld, EX_MEM_Ld, MEM_WB_Ld,
                IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush,
                Stall, MemReq, Err};

  function automatic step_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                               input logic jump, input logic exRd, input logic [4:0] exRt,
                               input logic br, input logic acc, input logic rdy,
                               input logic [11:0] ctl, input logic [CNT_W-1:0] cnt);
    step_t s;
    s.rst = rst; s.rs = rs; s.rt = rt; s.jump = jump; s.exRd = exRd; s.exRt = exRt;
    s.br = br; s.acc = acc; s.rdy = rdy; s.ctl = ctl; s.cnt = cnt;
    return s;
  endfunction

  // Applies one cycle of stimulus on the falling edge and queues what that cycle should show
  task automatic applyStimulus(input step_t s);
    @(negedge Clk);
    Rst            = s.rst;
    ID_Rs          = s.rs;
    ID_Rt          = s.rt;
    ID_Jump        = s.jump;
    EX_MemRead     = s.exRd;
    EX_Rt          = s.exRt;
    EX_BranchTaken = s.br;
    MEM_MemAccess  = s.acc;
    MemReady       = s.rdy;
    sb.push_back('{ctl: s.ctl, cnt: s.cnt});
  endtask

  // Unchecked reset pulse so each scenario starts in RUN with a zero count
  task automatic pulseReset();
    @(negedge Clk);
    Rst = 1'b1;
    ID_Rs = '0; ID_Rt = '0; ID_Jump = 1'b0; EX_MemRead = 1'b0; EX_Rt = '0;
    EX_BranchTaken = 1'b0; MEM_MemAccess = 1'b0; MemReady = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(1, 8, 0, 0, 1, 8, 0, 0, 0, C_RST, 0));
    st.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, 0, C_RST, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
    foreach (st[i]) begin
      applyStimulus(st[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl) begin
        errors++;
        $display("[TB] FAIL reset step %0d ctl got %b want %b", i, obs, e.ctl);
      end
      checks++;
      if (StallCycles !== e.cnt) begin
        errors++;
        $display("[TB] FAIL reset step %0d StallCycles got %0d want %0d", i, StallCycles, e.cnt);
      end
    end
  endtask

  task automatic test_load_use();
    step_t st[$];
    exp_t  e;
    pulseReset();
    st.push_back(mk(0, 8, 3, 0, 1, 8, 0, 0, 0, C_LU, 0));
    st.push_back(mk(0, 8, 3, 0, 0, 0, 0, 0, 0, C_NONE, 1));
    st.push_back(mk(0, 3, 9, 0, 1, 9, 0, 0, 0, C_LU, 1));
    st.push_back(mk(0, 3, 9, 0, 0, 0, 0, 0, 0, C_NONE, 2));
    st.push_back(mk(0, 8, 10, 0, 1, 9, 0, 0, 0, C_NONE, 2));
    st.push_back(mk(0, 8, 8, 0, 0, 8, 0, 0, 0, C_NONE, 2));
    foreach (st[i]) begin
      applyStimulus(st[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl) begin
        errors++;
        $display("[TB] FAIL load_use step %0d ctl got %b want %b", i, obs, e.ctl);
      end
      checks++;
      if (StallCycles !== e.cnt) begin
        errors++;
        $display("[TB] FAIL load_use step %0d StallCycles got %0d want %0d", i, StallCycles, e.cnt);
      end
    end
  endtask

  task automatic test_reg_zero();
    step_t st[$];
    exp_t  e;
    pulseReset();
    st.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, C_NONE, 0));
    st.push_back(mk(0, 5, 0, 0, 1, 0, 0, 0, 0, C_NONE, 0));
    foreach (st[i]) begin
      applyStimulus(st[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl) begin
        errors++;
        $display("[TB] FAIL reg_zero step %0d ctl got %b want %b", i, obs, e.ctl);
      end
      checks++;
      if (StallCycles !== e.cnt) begin
        errors++;
        $display("[TB] FAIL reg_zero step %0d StallCycles got %0d want %0d", i, StallCycles, e.cnt);
      end
    end
  endtask

  task automatic test_priority();
    step_t st[$];
    exp_t  e;
    pulseReset();
    st.push_back(mk(0, 8, 0, 0, 1, 8, 1, 0, 0, C_BR, 0));
    st.push_back(mk(0, 8, 0, 1, 1, 8, 0, 0, 0, C_LU, 0));
    st.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, C_JMP, 1));
    st.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, C_BR, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1));
    foreach (st[i]) begin
      applyStimulus(st[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl) begin
        errors++;
        $display("[TB] FAIL priority step %0d ctl got %b want %b", i, obs, e.ctl);
      end
      checks++;
      if (StallCycles !== e.cnt) begin
        errors++;
        $display("[TB] FAIL priority step %0d StallCycles got %0d want %0d", i, StallCycles, e.cnt);
      end
    end
  endtask

  task automatic test_mem_wait();
    step_t st[$];
    exp_t  e;
    pulseReset();
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_MEMW, 1));
    st.push_back(mk(0, 8, 0, 0, 1, 8, 0, 1, 0, C_MEMW, 2));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, C_REL, 3));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 3));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 3));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM0, 3));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, C_RELBR, 4));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 4));
    foreach (st[i]) begin
      applyStimulus(st[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl) begin
        errors++;
        $display("[TB] FAIL mem_wait step %0d ctl got %b want %b", i, obs, e.ctl);
      end
      checks++;
      if (StallCycles !== e.cnt) begin
        errors++;
        $display("[TB] FAIL mem_wait step %0d StallCycles got %0d want %0d", i, StallCycles, e.cnt);
      end
    end
  endtask

  task automatic test_timeout();
    step_t st[$];
    exp_t  e;
    pulseReset();
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM0, 0));
    for (int k = 1; k <= 4; k++)
      st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEMW, CNT_W'(k)));
    for (int k = 5; k <= 19; k++)
      st.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 1, C_ERR, (k < 15) ? CNT_W'(k) : CNT_W'(15)));
    st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RSTERR, 15));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
    foreach (st[i]) begin
      applyStimulus(st[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl) begin
        errors++;
        $display("[TB] FAIL timeout step %0d ctl got %b want %b", i, obs, e.ctl);
      end
      checks++;
      if (StallCycles !== e.cnt) begin
        errors++;
        $display("[TB] FAIL timeout step %0d StallCycles got %0d want %0d", i, StallCycles, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    step_t st[$];
    exp_t  e;
    pulseReset();
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEMW, 1));
    st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, C_RSTREQ, 2));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
    foreach (st[i]) begin
      applyStimulus(st[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl) begin
        errors++;
        $display("[TB] FAIL reset_mid_wait step %0d ctl got %b want %b", i, obs, e.ctl);
      end
      checks++;
      if (StallCycles !== e.cnt) begin
        errors++;
        $display("[TB] FAIL reset_mid_wait step %0d StallCycles got %0d want %0d", i, StallCycles, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    exp_t  e;
    pulseReset();
    st.push_back(mk(0, 8, 0, 0, 1, 8, 0, 0, 0, C_LU, 0));
    st.push_back(mk(0, 8, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1));
    st.push_back(mk(0, 0, 12, 0, 1, 12, 0, 0, 0, C_LU, 1));
    st.push_back(mk(0, 0, 12, 0, 0, 0, 0, 0, 0, C_NONE, 2));
    st.push_back(mk(0, 7, 0, 0, 1, 7, 0, 1, 0, C_MEM0, 2));
    st.push_back(mk(0, 7, 0, 0, 1, 7, 0, 1, 1, C_RELLU, 3));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 4));
    foreach (st[i]) begin
      applyStimulus(st[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if (obs !== e.ctl) begin
        errors++;
        $display("[TB] FAIL back_to_back step %0d ctl got %b want %b", i, obs, e.ctl);
      end
      checks++;
      if (StallCycles !== e.cnt) begin
        errors++;
        $display("[TB] FAIL back_to_back step %0d StallCycles got %0d want %0d", i, StallCycles, e.cnt);
      end
    end
  endtask

  // Runs every scenario in order and prints the summary
  initial begin
    test_reset();
    test_load_use();
    test_reg_zero();
    test_priority();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
